// File: rtl/scramble_sched_pkg.sv
// Shared constants and FSM state type for the scrambler scheduler.
package scramble_sched_pkg;

  localparam int unsigned ICS_CINIT_W = 31;
  localparam int unsigned ICS_Q_W     = 4;
  localparam int unsigned LANES       = 12;
  localparam int unsigned QW          = 10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StRun,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/scramble_sched_fifo.sv
// Synchronous FIFO holding tagged scrambler words; exposes its fill count for credit tracking.
module scramble_sched_fifo #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Push while full is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    empty   = (count == '0);
    head    = empty ? '0 : mem[rd_ptr];
  end

  // Storage array, no reset needed: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/scramble_sched.sv
// Round-robin scheduler sharing one ICS scrambler between requesters, with credit-metered
// word requests into a small tagged output FIFO.
module scramble_sched
  import scramble_sched_pkg::*;
#(
  parameter int unsigned  NREQ      = 2,
  parameter int unsigned  LANES     = scramble_sched_pkg::LANES,
  parameter int unsigned  QW        = scramble_sched_pkg::QW,
  parameter int unsigned  LEN_W     = 16,
  parameter int unsigned  BUF_DEPTH = 4,
  parameter int unsigned  WARM_CYC  = 1,
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*ICS_CINIT_W-1:0] req_c_init,
  input  logic [NREQ*ICS_Q_W-1:0]     req_q_size,
  input  logic [NREQ*LEN_W-1:0]       req_len,
  output logic                        ics_start,
  output logic [ICS_CINIT_W-1:0]      ics_c_init,
  output logic [ICS_Q_W-1:0]          ics_q_size,
  output logic                        scramble_en,
  input  logic                        scramble_ready,
  input  logic [LANES*QW-1:0]         scramble_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*QW-1:0]         out_data,
  output logic [IDW-1:0]              out_id,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [IDW-1:0]              done_id,
  output logic                        err_ovf
);

  localparam int unsigned DW    = LANES * QW;
  localparam int unsigned FW    = DW + IDW + 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned GAP_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

  sched_state_e     state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] recv;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             zero_done;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_fire;
  logic [LEN_W-1:0] grant_len;
  logic [OCC_W-1:0] occ;
  logic             word_ok;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;

  // Round-robin pick: first valid requester strictly after the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = IDW'((int'(rr_ptr) + i) % int'(NREQ));
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Credit metering and handshake decode. No grant while a req_ready pulse is still out,
  // because the requester only drops req_valid after seeing it.
  always_comb begin
    grant_fire  = (state == StIdle) && grant_vld && (req_ready == '0);
    grant_len   = req_len[grant_idx*LEN_W +: LEN_W];
    occ         = OCC_W'(fifo_cnt) + OCC_W'(inflight);
    scramble_en = (state == StRun) && (issued != len_q) && (occ < OCC_W'(BUF_DEPTH));
    word_ok     = scramble_ready && (inflight != '0);
    out_valid   = !fifo_empty;
    busy        = (state != StIdle);
  end

  // Job FSM: grant, scrambler load, warm-up gap, metered run, drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      rr_ptr     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      req_ready  <= '0;
      ics_start  <= 1'b0;
      ics_c_init <= '0;
      ics_q_size <= '0;
      gap_cnt    <= '0;
      zero_done  <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
    end else begin
      req_ready <= '0;
      ics_start <= 1'b0;
      done      <= 1'b0;
      zero_done <= 1'b0;
      if (zero_done) begin
        done    <= 1'b1;
        done_id <= id_q;
      end
      unique case (state)
        StIdle: begin
          if (grant_fire) begin
            req_ready  <= NREQ'(1) << grant_idx;
            rr_ptr     <= grant_idx;
            id_q       <= grant_idx;
            len_q      <= grant_len;
            ics_c_init <= req_c_init[grant_idx*ICS_CINIT_W +: ICS_CINIT_W];
            ics_q_size <= req_q_size[grant_idx*ICS_Q_W +: ICS_Q_W];
            if (grant_len == '0) begin
              zero_done <= 1'b1;
            end else begin
              ics_start <= 1'b1;
              state     <= StLoad;
            end
          end
        end
        StLoad: begin
          gap_cnt <= '0;
          state   <= (WARM_CYC == 0) ? StRun : StGap;
        end
        StGap: begin
          if (32'(gap_cnt) == WARM_CYC - 1) state <= StRun;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        StRun: begin
          if (issued == len_q) state <= StDrain;
        end
        StDrain: begin
          if ((inflight == '0) && (fifo_cnt == '0)) begin
            state   <= StIdle;
            done    <= 1'b1;
            done_id <= id_q;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Word counters, in-flight tracking and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued   <= '0;
      recv     <= '0;
      inflight <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (grant_fire) begin
        issued <= '0;
        recv   <= '0;
      end else begin
        if (scramble_en) issued <= issued + 1'b1;
        if (word_ok)     recv   <= recv + 1'b1;
      end
      unique case ({scramble_en, word_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      if (scramble_ready && (inflight == '0)) err_ovf <= 1'b1;
    end
  end

  scramble_sched_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_ok),
    .push_data ({id_q, (recv == len_q - LEN_W'(1)), scramble_data}),
    .pop       (out_valid && out_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign out_data = fifo_head[DW-1:0];
  assign out_last = fifo_head[DW];
  assign out_id   = fifo_head[FW-1 -: IDW];

endmodule

// File: tb/tb_scramble_sched.sv
// Randomised bench for scramble_sched with a job-level reference model and a scrambler stub.
module tb_scramble_sched;
  import scramble_sched_pkg::*;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned WARM_CYC  = 1;
  localparam int unsigned IDW       = 1;
  localparam int unsigned DW        = LANES * QW;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*ICS_CINIT_W-1:0] req_c_init;
  logic [NREQ*ICS_Q_W-1:0]     req_q_size;
  logic [NREQ*LEN_W-1:0]       req_len;
  logic                        ics_start;
  logic [ICS_CINIT_W-1:0]      ics_c_init;
  logic [ICS_Q_W-1:0]          ics_q_size;
  logic                        scramble_en;
  logic                        scramble_ready;
  logic [DW-1:0]               scramble_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DW-1:0]               out_data;
  logic [IDW-1:0]              out_id;
  logic                        out_last;
  logic                        busy;
  logic                        done;
  logic [IDW-1:0]              done_id;
  logic                        err_ovf;

  always #5 clk = ~clk;

  scramble_sched #(
    .NREQ      (NREQ),
    .LANES     (LANES),
    .QW        (QW),
    .LEN_W     (LEN_W),
    .BUF_DEPTH (BUF_DEPTH),
    .WARM_CYC  (WARM_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_c_init     (req_c_init),
    .req_q_size     (req_q_size),
    .req_len        (req_len),
    .ics_start      (ics_start),
    .ics_c_init     (ics_c_init),
    .ics_q_size     (ics_q_size),
    .scramble_en    (scramble_en),
    .scramble_ready (scramble_ready),
    .scramble_data  (scramble_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_id         (out_id),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .done_id        (done_id),
    .err_ovf        (err_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: job table, pending set, RR pointer, expected word stream.
  logic [30:0]    jc [NREQ];
  logic [3:0]     jq [NREQ];
  logic [15:0]    jl [NREQ];
  logic [NREQ-1:0] pend;
  int             m_rr;
  logic [DW-1:0]  exp_data [$];
  logic [IDW-1:0] exp_id [$];
  logic           exp_last [$];
  int             done_q [$];

  // Scrambler stub: two-stage latency from scramble_en to scramble_ready.
  logic [30:0]   sc_c;
  logic [3:0]    sc_q;
  int            sc_k;
  logic          s0v, s1v, spur;
  logic [DW-1:0] s0d, s1d;

  int n_ics, n_en, n_rdy;
  logic [NREQ-1:0] rr_seen;
  logic            done_seen, busy_seen;
  logic [IDW-1:0]  done_id_seen;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [IDW-1:0] ix(input int i);
    return IDW'(i);
  endfunction

  // Golden scrambler word for word k of a job loaded with (c, q).
  function automatic logic [DW-1:0] gold(input logic [30:0] c, input logic [3:0] q, input int k);
    logic [DW-1:0] w;
    logic [31:0]   h;
    w = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      h = {1'b0, c} ^ (32'(k) * 32'h9E3779B1) ^ (32'(l) * 32'h85EBCA6B) ^ {28'd0, q};
      h = h ^ (h >> 13);
      w[l*QW +: QW] = h[QW-1:0];
    end
    return w;
  endfunction

  function automatic int pick();
    for (int i = 1; i <= int'(NREQ); i++) begin
      int k = (m_rr + i) % int'(NREQ);
      if (pend[ix(k)]) return k;
    end
    return -1;
  endfunction

  task automatic monitor();
    int g, eg;
    logic nv;
    logic [DW-1:0] nd;
    rr_seen = req_ready;
    done_seen = done;
    done_id_seen = done_id;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", DW'(done), DW'(0));
      else begin
        check("done_id", DW'(done_id), DW'(done_q.pop_front()));
        check("done_after_words", DW'(exp_data.size()), DW'(0));
      end
    end
    if (req_ready != '0) begin
      g = 0;
      for (int i = 0; i < int'(NREQ); i++) if (req_ready[ix(i)]) g = i;
      check("grant_onehot", DW'($countones(req_ready)), DW'(1));
      eg = pick();
      check("grant_idx", DW'(g), DW'(eg));
      if (eg >= 0) begin
        m_rr = eg;
        pend[ix(eg)] = 1'b0;
        for (int j = 0; j < int'(jl[ix(eg)]); j++) begin
          exp_data.push_back(gold(jc[ix(eg)], jq[ix(eg)], j));
          exp_id.push_back(ix(eg));
          exp_last.push_back(j == int'(jl[ix(eg)]) - 1);
        end
        done_q.push_back(eg);
      end
      req_valid[ix(g)] = 1'b0;
    end
    if (ics_start) begin
      n_ics++;
      check("ics_c_init", DW'(ics_c_init), DW'(jc[ix(m_rr)]));
      check("ics_q_size", DW'(ics_q_size), DW'(jq[ix(m_rr)]));
      sc_c = ics_c_init;
      sc_q = ics_q_size;
      sc_k = 0;
    end
    nv = scramble_en;
    nd = scramble_en ? gold(sc_c, sc_q, sc_k) : '0;
    if (scramble_en) begin
      n_en++;
      sc_k++;
    end
    scramble_ready = s1v | spur;
    scramble_data = s1d;
    if (s1v) n_rdy++;
    s1v = s0v; s1d = s0d; s0v = nv; s0d = nd; spur = 1'b0;
    if (out_valid) begin
      if (exp_data.size() == 0) check("out_unexpected", DW'(out_valid), DW'(0));
      else begin
        check("out_data", out_data, exp_data[0]);
        check("out_id", DW'(out_id), DW'(exp_id[0]));
        check("out_last", DW'(out_last), DW'(exp_last[0]));
        if (out_ready) begin
          void'(exp_data.pop_front());
          void'(exp_id.pop_front());
          void'(exp_last.pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic add_job(input int r, input logic [30:0] c, input logic [3:0] q,
                         input logic [15:0] len);
    jc[ix(r)] = c; jq[ix(r)] = q; jl[ix(r)] = len;
    req_c_init[r*ICS_CINIT_W +: ICS_CINIT_W] = c;
    req_q_size[r*ICS_Q_W +: ICS_Q_W] = q;
    req_len[r*LEN_W +: LEN_W] = len;
    req_valid[ix(r)] = 1'b1;
    pend[ix(r)] = 1'b1;
  endtask

  task automatic run_until_idle(input string tag, input int maxc, input logic rnd);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rnd) out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (pend == '0 && exp_data.size() == 0 && done_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    check(tag, DW'(ok), DW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int ics0, en0, rdy0, njobs;
    logic seen;
    rst = 1'b1;
    req_valid = '0; req_c_init = '0; req_q_size = '0; req_len = '0;
    out_ready = 1'b1; scramble_ready = 1'b0; scramble_data = '0;
    pend = '0; m_rr = 0; s0v = 0; s1v = 0; s0d = '0; s1d = '0; spur = 0;
    sc_c = '0; sc_q = '0; sc_k = 0; n_ics = 0; n_en = 0; n_rdy = 0;
    busy_seen = 0; rr_seen = '0; done_seen = 0; done_id_seen = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_scramble_en", DW'(scramble_en), DW'(0));
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_ics_start", DW'(ics_start), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_err_ovf", DW'(err_ovf), DW'(0));
    rst = 1'b0;
    step();

    // Single job.
    ics0 = n_ics;
    add_job(0, 31'h1234, 4'd2, 16'd3);
    run_until_idle("single_idle", 200, 1'b0);
    check("single_ics_count", DW'(n_ics - ics0), DW'(1));

    // Two simultaneous requests with RR pointer at 0: requester 1 first.
    ics0 = n_ics;
    add_job(0, 31'h0ABC_DEF0, 4'd4, 16'd2);
    add_job(1, 31'h7555_1111, 4'd6, 16'd2);
    run_until_idle("arb_idle", 300, 1'b0);
    check("arb_ics_count", DW'(n_ics - ics0), DW'(2));

    // Backpressure: downstream stalled, requests must stop at the FIFO depth.
    en0 = n_en;
    out_ready = 1'b0;
    add_job(0, 31'h2468_ACE0, 4'd8, 16'd10);
    repeat (20) step();
    check("bp_en_count", DW'(n_en - en0), DW'(BUF_DEPTH));
    check("bp_out_valid", DW'(out_valid), DW'(1));
    check("bp_err_ovf", DW'(err_ovf), DW'(0));
    out_ready = 1'b1;
    run_until_idle("bp_idle", 300, 1'b0);
    check("bp_err_ovf_end", DW'(err_ovf), DW'(0));

    // Zero-length job: accepted, done next cycle, scrambler untouched.
    ics0 = n_ics; en0 = n_en; busy_seen = 1'b0; seen = 1'b0;
    add_job(0, 31'h0000_0055, 4'd2, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (rr_seen[0]) begin
        seen = 1'b1;
        step();
        check("zlen_done", DW'(done_seen), DW'(1));
        check("zlen_done_id", DW'(done_id_seen), DW'(0));
        break;
      end
    end
    check("zlen_grant_seen", DW'(seen), DW'(1));
    run_until_idle("zlen_idle", 50, 1'b0);
    check("zlen_ics", DW'(n_ics - ics0), DW'(0));
    check("zlen_en", DW'(n_en - en0), DW'(0));
    check("zlen_busy", DW'(busy_seen), DW'(0));

    // Random batches with random downstream stalls.
    ics0 = n_ics; njobs = 0;
    for (int b = 0; b < 25; b++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int r = 0; r < int'(NREQ); r++) begin
        if (mask[r]) begin
          logic [15:0] l;
          l = 16'($urandom_range(0, 7));
          if (l != 0) njobs++;
          add_job(r, 31'($urandom), 4'($urandom), l);
        end
      end
      run_until_idle("rand_idle", 400, 1'b1);
    end
    check("rand_ics_count", DW'(n_ics - ics0), DW'(njobs));
    check("rand_err_ovf", DW'(err_ovf), DW'(0));

    // Spurious scrambler word while idle.
    spur = 1'b1;
    step();
    step();
    check("spur_err_ovf", DW'(err_ovf), DW'(1));
    check("spur_out_valid", DW'(out_valid), DW'(0));
    repeat (5) step();
    check("spur_err_sticky", DW'(err_ovf), DW'(1));

    // Reset in the middle of a job with two words buffered.
    out_ready = 1'b0;
    rdy0 = n_rdy; seen = 1'b0;
    add_job(0, 31'h3333_4444, 4'd6, 16'd8);
    for (int i = 0; i < 50; i++) begin
      step();
      if (n_rdy - rdy0 >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_buffered", DW'(seen), DW'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", DW'(out_valid), DW'(0));
    check("rst_mid_busy", DW'(busy), DW'(0));
    check("rst_mid_scramble_en", DW'(scramble_en), DW'(0));
    exp_data.delete(); exp_id.delete(); exp_last.delete(); done_q.delete();
    pend = '0; req_valid = '0; m_rr = 0;
    s0v = 0; s1v = 0; spur = 0; scramble_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_err_clear", DW'(err_ovf), DW'(0));
    add_job(0, 31'h0101_0101, 4'd2, 16'd3);
    add_job(1, 31'h0202_0202, 4'd4, 16'd4);
    run_until_idle("post_rst_idle", 300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
